cdr_link_ctrl: RTL and testbench
================================

Name: cdr_link_ctrl

Overview:
Link bring-up and supervision controller for the 4x-oversampling CDR on the coax receive path.
- Sequences the CDR: holds it in reset, waits for lock, and qualifies lock stability.
- Hunts a sync word in the recovered bit stream, then gates the data bits through to the deframer.
- Monitors for loss of lock or loss of bit strobes and retrains with a bounded retry count.
- Sits between cdr_4x_oversampling and the downstream frame logic, in the clk_link domain.

Parameters:
- RESET_CYC, 8: cycles cdr_rst_n is held low per training attempt.
- LOCK_TIMEOUT, 2048: max cycles in WAIT_LOCK before a failed attempt.
- LOCK_STABLE_CYC, 64: consecutive cycles cdr_locked must stay high.
- SYNC_W, 16: sync word width.
- SYNC_WORD, 16'hA5C3: sync pattern, MSB received first.
- SYNC_TIMEOUT, 4096: max cycles in HUNT_SYNC.
- VALID_TIMEOUT, 16: max cycles between cdr_bit_valid pulses in LINK_UP.
- MAX_RETRY, 3: failed attempts tolerated before FAIL.

Ports:
- clk_link, input, 1: link clock (200 MHz). The block uses one clock.
- rst, input, 1: reset, asynchronous and active-high.
- enable, input, 1: link enable.
- cdr_locked, input, 1: CDR lock indication.
- cdr_bit, input, 1: recovered bit.
- cdr_bit_valid, input, 1: recovered-bit strobe.
- cdr_rst_n, output, 1: CDR reset, active-low.
- train_req, output, 1: request to the far end to send the alternating training pattern.
- data_bit, output, 1: payload bit.
- data_valid, output, 1: payload strobe.
- link_up, output, 1: link established.
- link_fail, output, 1: retries exhausted.
- retry_cnt, output, $clog2(MAX_RETRY+1): failed attempts since last LINK_UP.
- state, output, 3: FSM state, for debug.

Behaviour:
- Reset values (rst high, asynchronous):
  - state = IDLE, cdr_rst_n = 0, train_req = 0, data_bit = 0, data_valid = 0, link_up = 0, link_fail = 0, retry_cnt = 0.
  - All counters and the shift register = 0.
- State encoding: IDLE=0, RESET_CDR=1, WAIT_LOCK=2, LOCK_STABLE=3, HUNT_SYNC=4, LINK_UP=5, FAIL=6.
- All outputs are registered and decoded from the current state; the cycle counter restarts on every state entry.
- IDLE:
  - cdr_rst_n = 0.
  - enable=1 -> RESET_CDR.
- RESET_CDR:
  - cdr_rst_n = 0, train_req = 1.
  - After RESET_CYC cycles -> WAIT_LOCK.
- WAIT_LOCK:
  - cdr_rst_n = 1, train_req = 1.
  - cdr_locked=1 -> LOCK_STABLE.
  - LOCK_TIMEOUT cycles elapsed -> failure event.
- LOCK_STABLE:
  - cdr_locked must stay high for LOCK_STABLE_CYC consecutive cycles -> HUNT_SYNC.
  - Any low cycle -> WAIT_LOCK. This does not count as a failure; the LOCK_TIMEOUT count restarts.
- HUNT_SYNC:
  - train_req = 1.
  - On each cdr_bit_valid: sr <= {sr[SYNC_W-2:0], cdr_bit}.
  - If the post-shift value equals SYNC_WORD -> LINK_UP in that same cycle; the matching bits are not emitted.
  - cdr_locked=0 or SYNC_TIMEOUT elapsed -> failure event.
  - sr clears on entry to HUNT_SYNC.
- LINK_UP:
  - link_up = 1, train_req = 0; retry_cnt clears on entry.
  - data_valid/data_bit = cdr_bit_valid/cdr_bit, registered (1-cycle latency).
  - The first emitted bit is the first valid bit after the sync match.
  - cdr_locked=0, or VALID_TIMEOUT cycles without cdr_bit_valid -> failure event. data_valid = 0 from the cycle after detection.
- Failure event:
  - If retry_cnt == MAX_RETRY -> FAIL.
  - Otherwise retry_cnt++ and -> RESET_CDR.
  - retry_cnt saturates; it never wraps.
- FAIL:
  - link_fail = 1, cdr_rst_n = 0, train_req = 0.
  - Held until enable=0.
- enable=0 in any state:
  - Next cycle -> IDLE; retry_cnt, link_fail and data_valid clear.
  - Overrides all other transitions in the same cycle.
- Simultaneous events:
  - Sync match and cdr_locked drop in the same cycle: the failure wins.
  - A timeout and cdr_locked rising in WAIT_LOCK in the same cycle: the lock wins.

Test Plan:
- Nominal bring-up: rst pulse; enable=1; CDR model locks 300 cycles after cdr_rst_n rises; send 1010… then 0xA5C3 then 1,1,0,1.
  - cdr_rst_n low for exactly 8 cycles.
  - link_up rises 1 cycle after the match.
  - data_valid pulses carry bits 1,1,0,1.
  - retry_cnt = 0.
- Lock glitch: cdr_locked drops for 1 cycle at LOCK_STABLE cycle 40.
  - Returns to WAIT_LOCK; retry_cnt stays 0.
  - Link comes up after 64 further clean cycles.
- Loss of link: in LINK_UP, stop cdr_bit_valid for 16 cycles.
  - link_up falls, state=RESET_CDR, retry_cnt=1, train_req=1.
  - Re-sync returns LINK_UP with retry_cnt=0.
- Retry exhaustion: cdr_locked held 0.
  - Four LOCK_TIMEOUT expiries, with retry_cnt stepping 1,2,3.
  - Then state=FAIL, link_fail=1, cdr_rst_n=0.
  - enable=0 -> IDLE with retry_cnt=0.
- Sync false-match guard: send 0xA5C2 repeatedly.
  - No LINK_UP.
  - SYNC_TIMEOUT at 4096 cycles -> retry_cnt=1.
- Async reset mid-LINK_UP: assert rst between clock edges.
  - All outputs reach reset values immediately, without waiting for a clock edge.
  - After release, bring-up restarts from IDLE.

Source files
------------

// File: rtl/cdr_link_ctrl.sv
// Link bring-up and supervision controller for the 4x-oversampling CDR.
// Sequences CDR reset/lock, hunts the sync word, gates payload, retrains on loss.
module cdr_link_ctrl #(
    parameter int              RESET_CYC       = 8,
    parameter int              LOCK_TIMEOUT    = 2048,
    parameter int              LOCK_STABLE_CYC = 64,
    parameter int              SYNC_W          = 16,
    parameter logic [SYNC_W-1:0] SYNC_WORD     = 16'hA5C3,
    parameter int              SYNC_TIMEOUT    = 4096,
    parameter int              VALID_TIMEOUT   = 16,
    parameter int              MAX_RETRY       = 3
) (
    input  logic                             clk_link,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             cdr_locked,
    input  logic                             cdr_bit,
    input  logic                             cdr_bit_valid,
    output logic                             cdr_rst_n,
    output logic                             train_req,
    output logic                             data_bit,
    output logic                             data_valid,
    output logic                             link_up,
    output logic                             link_fail,
    output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
    output logic [2:0]                       state
);

    localparam int RW    = $clog2(MAX_RETRY + 1);
    localparam int M1    = (LOCK_TIMEOUT > SYNC_TIMEOUT) ? LOCK_TIMEOUT : SYNC_TIMEOUT;
    localparam int M2    = (RESET_CYC > LOCK_STABLE_CYC) ? RESET_CYC : LOCK_STABLE_CYC;
    localparam int M3    = (M2 > VALID_TIMEOUT) ? M2 : VALID_TIMEOUT;
    localparam int CMAX  = (M1 > M3) ? M1 : M3;
    localparam int CW    = $clog2(CMAX + 1);

    localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYC - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE_CYC - 1);
    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_TIMEOUT - 1);
    localparam logic [CW-1:0] VAL_LAST  = CW'(VALID_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        RESET_CDR   = 3'd1,
        WAIT_LOCK   = 3'd2,
        LOCK_STABLE = 3'd3,
        HUNT_SYNC   = 3'd4,
        LINK_UP     = 3'd5,
        FAIL        = 3'd6
    } state_t;

    state_t            cur;
    state_t            nxt;
    logic [CW-1:0]     cnt;
    logic [SYNC_W-1:0] sr;
    logic [SYNC_W-1:0] sr_shift;
    logic              match;
    logic              fail_ev;
    logic              retry_inc;
    logic              cdr_rst_n_d;
    logic              train_req_d;
    logic              pass_d;

    assign state    = cur;
    assign sr_shift = {sr[SYNC_W-2:0], cdr_bit};
    assign match    = cdr_bit_valid && (sr_shift == SYNC_WORD);

    always_comb begin
        nxt       = cur;
        fail_ev   = 1'b0;
        retry_inc = 1'b0;
        unique case (cur)
            IDLE:        if (enable) nxt = RESET_CDR;
            RESET_CDR:   if (cnt == RST_LAST) nxt = WAIT_LOCK;
            WAIT_LOCK: begin
                if (cdr_locked)             nxt     = LOCK_STABLE;
                else if (cnt == LOCK_LAST)  fail_ev = 1'b1;
            end
            LOCK_STABLE: begin
                if (!cdr_locked)            nxt = WAIT_LOCK;
                else if (cnt == STB_LAST)   nxt = HUNT_SYNC;
            end
            HUNT_SYNC: begin
                if (!cdr_locked)            fail_ev = 1'b1;
                else if (match)             nxt     = LINK_UP;
                else if (cnt == SYNC_LAST)  fail_ev = 1'b1;
            end
            LINK_UP: begin
                if (!cdr_locked)            fail_ev = 1'b1;
                else if (!cdr_bit_valid && cnt == VAL_LAST) fail_ev = 1'b1;
            end
            FAIL:        nxt = FAIL;
            default:     nxt = IDLE;
        endcase
        if (fail_ev) begin
            if (retry_cnt == RETRY_MAX) begin
                nxt = FAIL;
            end else begin
                nxt       = RESET_CDR;
                retry_inc = 1'b1;
            end
        end
        // Disable beats every other transition, including a failure event.
        if (!enable) begin
            nxt       = IDLE;
            retry_inc = 1'b0;
        end
    end

    always_comb begin
        cdr_rst_n_d = 1'b0;
        train_req_d = 1'b0;
        unique case (nxt)
            RESET_CDR:   train_req_d = 1'b1;
            WAIT_LOCK,
            LOCK_STABLE,
            HUNT_SYNC: begin
                cdr_rst_n_d = 1'b1;
                train_req_d = 1'b1;
            end
            LINK_UP:     cdr_rst_n_d = 1'b1;
            default: begin
                cdr_rst_n_d = 1'b0;
                train_req_d = 1'b0;
            end
        endcase
        pass_d = (cur == LINK_UP) && (nxt == LINK_UP) && cdr_bit_valid;
    end

    always_ff @(posedge clk_link or posedge rst) begin
        if (rst) begin
            cur <= IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // Cycle counter: restarts on every state entry; in LINK_UP also on each strobe.
    always_ff @(posedge clk_link or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (nxt != cur) begin
            cnt <= '0;
        end else if (cur == IDLE || cur == FAIL) begin
            cnt <= '0;
        end else if (cur == LINK_UP && cdr_bit_valid) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_link or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (nxt == HUNT_SYNC && cur != HUNT_SYNC) begin
            sr <= '0;
        end else if (cur == HUNT_SYNC && cdr_bit_valid) begin
            sr <= sr_shift;
        end
    end

    always_ff @(posedge clk_link or posedge rst) begin
        if (rst) begin
            retry_cnt <= '0;
        end else if (!enable) begin
            retry_cnt <= '0;
        end else if (nxt == LINK_UP && cur != LINK_UP) begin
            retry_cnt <= '0;
        end else if (retry_inc && retry_cnt != RETRY_MAX) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_link or posedge rst) begin
        if (rst) begin
            cdr_rst_n  <= 1'b0;
            train_req  <= 1'b0;
            link_up    <= 1'b0;
            link_fail  <= 1'b0;
            data_valid <= 1'b0;
            data_bit   <= 1'b0;
        end else begin
            cdr_rst_n  <= cdr_rst_n_d;
            train_req  <= train_req_d;
            link_up    <= (nxt == LINK_UP);
            link_fail  <= (nxt == FAIL);
            data_valid <= pass_d;
            if (pass_d) begin
                data_bit <= cdr_bit;
            end
        end
    end

endmodule

// File: tb/tb_cdr_link_ctrl.sv
// Directed bench for cdr_link_ctrl: bring-up, glitches, loss, retries,
// false sync guard and asynchronous reset.
module tb_cdr_link_ctrl;

    logic       clk_link = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       cdr_locked = 1'b0;
    logic       cdr_bit = 1'b0;
    logic       cdr_bit_valid = 1'b0;
    logic       cdr_rst_n;
    logic       train_req;
    logic       data_bit;
    logic       data_valid;
    logic       link_up;
    logic       link_fail;
    logic [1:0] retry_cnt;
    logic [2:0] state;

    int passed = 0;
    int total  = 0;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RST  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_STB  = 3'd3;
    localparam logic [2:0] S_HUNT = 3'd4;
    localparam logic [2:0] S_UP   = 3'd5;
    localparam logic [2:0] S_FAIL = 3'd6;

    cdr_link_ctrl dut (
        .clk_link      (clk_link),
        .rst           (rst),
        .enable        (enable),
        .cdr_locked    (cdr_locked),
        .cdr_bit       (cdr_bit),
        .cdr_bit_valid (cdr_bit_valid),
        .cdr_rst_n     (cdr_rst_n),
        .train_req     (train_req),
        .data_bit      (data_bit),
        .data_valid    (data_valid),
        .link_up       (link_up),
        .link_fail     (link_fail),
        .retry_cnt     (retry_cnt),
        .state         (state)
    );

    always #5 clk_link = ~clk_link;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_link);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (state !== s) $display("FAIL wait_state got %0d want %0d", state, s);
        else passed++;
    endtask

    task automatic send_bit(input logic b, output logic dv, output logic db);
        cdr_bit       = b;
        cdr_bit_valid = 1'b1;
        tick();
        dv            = data_valid;
        db            = data_bit;
        cdr_bit_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_sync(output logic lu_pre, output logic lu_post, output logic dv_post);
        logic [15:0] w;
        logic        dv;
        logic        db;
        w = 16'hA5C3;
        for (int i = 0; i < 8; i++) send_bit(~i[0], dv, db);
        for (int i = 15; i >= 1; i--) send_bit(w[i], dv, db);
        lu_pre        = link_up;
        cdr_bit       = w[0];
        cdr_bit_valid = 1'b1;
        tick();
        lu_post       = link_up;
        dv_post       = data_valid;
        cdr_bit_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        total++; if (state !== S_IDLE) $display("FAIL rst_state got %0d want 0", state); else passed++;
        total++; if (cdr_rst_n !== 1'b0) $display("FAIL rst_cdr_rst_n got %b want 0", cdr_rst_n); else passed++;
        total++; if (train_req !== 1'b0) $display("FAIL rst_train_req got %b want 0", train_req); else passed++;
        total++; if ({data_valid, data_bit} !== 2'b00) $display("FAIL rst_data got %b want 00", {data_valid, data_bit}); else passed++;
        total++; if ({link_up, link_fail} !== 2'b00) $display("FAIL rst_link got %b want 00", {link_up, link_fail}); else passed++;
        total++; if (retry_cnt !== 2'd0) $display("FAIL rst_retry got %0d want 0", retry_cnt); else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        int n;
        logic lu_pre, lu_post, dv_post, dv, db;
        logic [3:0] pay;
        pay    = 4'b1101;
        enable = 1'b1;
        tick();
        total++; if (state !== S_RST) $display("FAIL nom_enter_rst got %0d want 1", state); else passed++;
        total++; if (train_req !== 1'b1) $display("FAIL nom_train_req got %b want 1", train_req); else passed++;
        n = 0;
        while (cdr_rst_n === 1'b0 && n < 100) begin
            n++;
            tick();
        end
        total++; if (n != 8) $display("FAIL nom_rst_len got %0d want 8", n); else passed++;
        repeat (300) tick();
        total++; if (state !== S_WAIT) $display("FAIL nom_wait got %0d want 2", state); else passed++;
        cdr_locked = 1'b1;
        tick();
        n = 0;
        while (state === S_STB && n < 200) begin
            n++;
            tick();
        end
        total++; if (n != 64) $display("FAIL nom_stable_len got %0d want 64", n); else passed++;
        total++; if (state !== S_HUNT) $display("FAIL nom_hunt got %0d want 4", state); else passed++;
        send_sync(lu_pre, lu_post, dv_post);
        total++; if (lu_pre !== 1'b0) $display("FAIL nom_lu_early got %b want 0", lu_pre); else passed++;
        total++; if (lu_post !== 1'b1) $display("FAIL nom_lu_after_match got %b want 1", lu_post); else passed++;
        total++; if (dv_post !== 1'b0) $display("FAIL nom_sync_not_emitted got %b want 0", dv_post); else passed++;
        for (int i = 3; i >= 0; i--) begin
            send_bit(pay[i], dv, db);
            total++;
            if ({dv, db} !== {1'b1, pay[i]}) $display("FAIL nom_payload_%0d got %b want %b", 3 - i, {dv, db}, {1'b1, pay[i]});
            else passed++;
        end
        total++; if (retry_cnt !== 2'd0) $display("FAIL nom_retry got %0d want 0", retry_cnt); else passed++;
    endtask

    task automatic test_loss_of_link();
        logic lu_pre, lu_post, dv_post;
        repeat (12) tick();
        total++; if (link_up !== 1'b1) $display("FAIL loss_still_up got %b want 1", link_up); else passed++;
        tick();
        total++; if (link_up !== 1'b0) $display("FAIL loss_link_up got %b want 0", link_up); else passed++;
        total++; if (state !== S_RST) $display("FAIL loss_state got %0d want 1", state); else passed++;
        total++; if (retry_cnt !== 2'd1) $display("FAIL loss_retry got %0d want 1", retry_cnt); else passed++;
        total++; if (train_req !== 1'b1) $display("FAIL loss_train_req got %b want 1", train_req); else passed++;
        total++; if (data_valid !== 1'b0) $display("FAIL loss_data_valid got %b want 0", data_valid); else passed++;
        wait_state(S_HUNT, 200);
        send_sync(lu_pre, lu_post, dv_post);
        total++; if (lu_post !== 1'b1) $display("FAIL loss_resync got %b want 1", lu_post); else passed++;
        total++; if (retry_cnt !== 2'd0) $display("FAIL loss_retry_clear got %0d want 0", retry_cnt); else passed++;
    endtask

    task automatic test_lock_glitch();
        int n;
        logic lu_pre, lu_post, dv_post;
        enable     = 1'b0;
        cdr_locked = 1'b0;
        tick();
        total++; if (state !== S_IDLE) $display("FAIL glitch_idle got %0d want 0", state); else passed++;
        enable = 1'b1;
        wait_state(S_WAIT, 50);
        cdr_locked = 1'b1;
        tick();
        total++; if (state !== S_STB) $display("FAIL glitch_stable got %0d want 3", state); else passed++;
        repeat (40) tick();
        cdr_locked = 1'b0;
        tick();
        total++; if (state !== S_WAIT) $display("FAIL glitch_back_wait got %0d want 2", state); else passed++;
        total++; if (retry_cnt !== 2'd0) $display("FAIL glitch_retry got %0d want 0", retry_cnt); else passed++;
        cdr_locked = 1'b1;
        tick();
        n = 0;
        while (state === S_STB && n < 200) begin
            n++;
            tick();
        end
        total++; if (n != 64) $display("FAIL glitch_stable_len got %0d want 64", n); else passed++;
        send_sync(lu_pre, lu_post, dv_post);
        total++; if (lu_post !== 1'b1) $display("FAIL glitch_link_up got %b want 1", lu_post); else passed++;
    endtask

    task automatic test_false_match();
        int   n;
        bit   seen_up;
        logic [15:0] w;
        w          = 16'hA5C2;
        enable     = 1'b0;
        tick();
        enable     = 1'b1;
        cdr_locked = 1'b1;
        wait_state(S_HUNT, 200);
        n       = 0;
        seen_up = 1'b0;
        while (state === S_HUNT && n < 5000) begin
            cdr_bit_valid = (n % 4 == 0);
            cdr_bit       = w[15 - ((n / 4) % 16)];
            tick();
            if (link_up === 1'b1) seen_up = 1'b1;
            n++;
        end
        cdr_bit_valid = 1'b0;
        total++; if (seen_up) $display("FAIL false_no_link_up got 1 want 0"); else passed++;
        total++; if (n != 4096) $display("FAIL false_timeout_len got %0d want 4096", n); else passed++;
        total++; if (state !== S_RST) $display("FAIL false_state got %0d want 1", state); else passed++;
        total++; if (retry_cnt !== 2'd1) $display("FAIL false_retry got %0d want 1", retry_cnt); else passed++;
    endtask

    task automatic test_retry_exhaustion();
        int n;
        enable     = 1'b0;
        cdr_locked = 1'b0;
        tick();
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wait_state(S_WAIT, 50);
            n = 0;
            while (state === S_WAIT && n < 3000) begin
                n++;
                tick();
            end
            total++; if (n != 2048) $display("FAIL retry_timeout_%0d got %0d want 2048", i, n); else passed++;
            if (i < 4) begin
                total++;
                if ({state, retry_cnt} !== {S_RST, 2'(i)})
                    $display("FAIL retry_step_%0d got state %0d cnt %0d want state 1 cnt %0d", i, state, retry_cnt, i);
                else passed++;
            end
        end
        total++; if (state !== S_FAIL) $display("FAIL retry_fail_state got %0d want 6", state); else passed++;
        total++; if (link_fail !== 1'b1) $display("FAIL retry_link_fail got %b want 1", link_fail); else passed++;
        total++; if ({cdr_rst_n, train_req} !== 2'b00) $display("FAIL retry_fail_outs got %b want 00", {cdr_rst_n, train_req}); else passed++;
        total++; if (retry_cnt !== 2'd3) $display("FAIL retry_saturate got %0d want 3", retry_cnt); else passed++;
        repeat (10) tick();
        total++; if (state !== S_FAIL) $display("FAIL retry_fail_hold got %0d want 6", state); else passed++;
        enable = 1'b0;
        tick();
        total++; if (state !== S_IDLE) $display("FAIL retry_idle got %0d want 0", state); else passed++;
        total++; if ({retry_cnt, link_fail} !== 3'b000) $display("FAIL retry_clear got %b want 000", {retry_cnt, link_fail}); else passed++;
    endtask

    task automatic test_async_reset();
        logic lu_pre, lu_post, dv_post;
        enable     = 1'b1;
        cdr_locked = 1'b1;
        wait_state(S_HUNT, 500);
        send_sync(lu_pre, lu_post, dv_post);
        cdr_bit       = 1'b1;
        cdr_bit_valid = 1'b1;
        tick();
        cdr_bit_valid = 1'b0;
        total++; if ({link_up, data_valid, data_bit} !== 3'b111) $display("FAIL arst_pre got %b want 111", {link_up, data_valid, data_bit}); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++; if (state !== S_IDLE) $display("FAIL arst_state got %0d want 0", state); else passed++;
        total++; if ({cdr_rst_n, train_req} !== 2'b00) $display("FAIL arst_cdr got %b want 00", {cdr_rst_n, train_req}); else passed++;
        total++; if ({link_up, link_fail, data_valid, data_bit} !== 4'b0000) $display("FAIL arst_outs got %b want 0000", {link_up, link_fail, data_valid, data_bit}); else passed++;
        total++; if (retry_cnt !== 2'd0) $display("FAIL arst_retry got %0d want 0", retry_cnt); else passed++;
        #2;
        rst = 1'b0;
        total++; if (state !== S_IDLE) $display("FAIL arst_hold_idle got %0d want 0", state); else passed++;
        tick();
        total++; if (state !== S_RST) $display("FAIL arst_restart got %0d want 1", state); else passed++;
        wait_state(S_HUNT, 500);
        send_sync(lu_pre, lu_post, dv_post);
        total++; if (lu_post !== 1'b1) $display("FAIL arst_relink got %b want 1", lu_post); else passed++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_loss_of_link();
        test_lock_glitch();
        test_false_match();
        test_retry_exhaustion();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
